// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on mem_ready with a stall timeout, traps undefined opcodes and counts
// retired instructions.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond_eq,
  output logic                 pc_write_cond_ne,
  output logic                 pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           ALUOp,
  output logic [3:0]           state,
  output logic                 illegal_op,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // Counter only needs to reach WAIT_LIMIT-1 before the trap fires.
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_ERROR     = 4'd15
  } state_t;

  state_t        cur_state, nxt_state;
  logic [WW-1:0] wait_cnt;
  logic          wait_hit, in_wait, retire, set_illegal, set_timeout;
  logic [2:0]    imm_aluop;

  assign state    = cur_state;
  assign in_wait  = (cur_state == S_FETCH) || (cur_state == S_MEM_READ) || (cur_state == S_MEM_WRITE);
  assign wait_hit = (wait_cnt == WAIT_LAST) && !mem_ready;
  assign retire   = (nxt_state == S_FETCH) &&
                    ((cur_state == S_MEM_WB) || (cur_state == S_MEM_WRITE) ||
                     (cur_state == S_ALU_WB) || (cur_state == S_BRANCH));

  // ALU operation for immediate-format arithmetic/logic instructions.
  always_comb begin
    case (OP)
      OP_ORI:  imm_aluop = 3'b101;
      OP_LUI:  imm_aluop = 3'b100;
      OP_ANDI: imm_aluop = 3'b001;
      default: imm_aluop = 3'b110;
    endcase
  end

  // Next-state selection plus one-cycle pulses for the sticky trap flags.
  always_comb begin
    nxt_state   = cur_state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (cur_state)
      S_FETCH: begin
        if (mem_ready)     nxt_state = S_DECODE;
        else if (wait_hit) begin nxt_state = S_ERROR; set_timeout = 1'b1; end
      end
      S_DECODE: begin
        case (OP)
          OP_R:                              nxt_state = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI:  nxt_state = S_EXEC_I;
          OP_LW, OP_SW:                      nxt_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    nxt_state = S_BRANCH;
          default: begin nxt_state = S_ERROR; set_illegal = 1'b1; end
        endcase
      end
      S_MEM_ADDR:  nxt_state = (OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)     nxt_state = S_MEM_WB;
        else if (wait_hit) begin nxt_state = S_ERROR; set_timeout = 1'b1; end
      end
      S_MEM_WB:    nxt_state = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)     nxt_state = S_FETCH;
        else if (wait_hit) begin nxt_state = S_ERROR; set_timeout = 1'b1; end
      end
      S_EXEC_R:    nxt_state = S_ALU_WB;
      S_EXEC_I:    nxt_state = S_ALU_WB;
      S_ALU_WB:    nxt_state = S_FETCH;
      S_BRANCH:    nxt_state = S_FETCH;
      S_ERROR:     nxt_state = S_ERROR;
      default:     nxt_state = S_ERROR;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  // Stall counter: restarts on every state change, counts low mem_ready cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       wait_cnt <= '0;
    else if (nxt_state != cur_state) wait_cnt <= '0;
    else if (in_wait && !mem_ready)  wait_cnt <= wait_cnt + WW'(1);
  end

  // Sticky trap flags and the retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
      instr_count <= '0;
    end else begin
      if (set_illegal) illegal_op  <= 1'b1;
      if (set_timeout) mem_timeout <= 1'b1;
      if (retire)      instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // Datapath controls decoded from the current state; reset masks everything.
  always_comb begin
    pc_write         = 1'b0;
    pc_write_cond_eq = 1'b0;
    pc_write_cond_ne = 1'b0;
    pc_source        = 1'b0;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    reg_dst          = 1'b0;
    mem_to_reg       = 1'b0;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    ALUOp            = 3'b000;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ALUOp     = 3'b110;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ALUOp     = 3'b110;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOp     = 3'b110;
      end
      S_MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALUOp     = 3'b111;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOp     = imm_aluop;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (OP == OP_R);
        ALUOp     = (OP == OP_R) ? 3'b111 : imm_aluop;
      end
      S_BRANCH: begin
        alu_src_a        = 1'b1;
        pc_source        = 1'b1;
        pc_write_cond_eq = (OP == OP_BEQ);
        pc_write_cond_ne = (OP == OP_BNE);
      end
      default: ;
    endcase
    if (reset) begin
      pc_write         = 1'b0;
      pc_write_cond_eq = 1'b0;
      pc_write_cond_ne = 1'b0;
      pc_source        = 1'b0;
      i_or_d           = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_dst          = 1'b0;
      mem_to_reg       = 1'b0;
      reg_write        = 1'b0;
      alu_src_a        = 1'b0;
      alu_src_b        = 2'b00;
      ALUOp            = 3'b000;
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a shared-memory, multi-cycle MIPS datapath through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps.
- Supports the same opcode set and 3-bit ALUOp encoding as the single-cycle control unit: R=111, ADDI=110, ORI=101, LUI=100, LW=011, SW=010, ANDI=001, BEQ/BNE=000.
- Waits on a memory-ready handshake, times out stalled accesses, traps illegal opcodes and counts retired instructions.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles with mem_ready low in any memory-wait state before the FSM traps.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- OP  in  6  opcode from IR[31:26]; stable from DECODE until the instruction ends
- mem_ready  in  1  memory completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond_eq  out  1  PC load if ALU zero
- pc_write_cond_ne  out  1  PC load if ALU not zero
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- ALUOp  out  3  ALU operation code (encoding above)
- state  out  4  current state encoding
- illegal_op  out  1  sticky: undefined opcode was decoded
- mem_timeout  out  1  sticky: memory wait reached WAIT_LIMIT
- instr_count  out  CNT_WIDTH  retired instructions

Behaviour:
Reset:
- While reset is high, the state register is forced to FETCH.
- The wait counter, instr_count, illegal_op and mem_timeout are cleared.
- All other outputs are forced to 0, including Mealy terms.
- Reset mid-instruction aborts the instruction without retiring it.

State encodings and outputs (any signal not listed is 0):
- FETCH (0): i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, ALUOp=110.
  - ir_write and pc_write equal mem_ready (Mealy).
  - Go to DECODE when mem_ready is high; otherwise stay.
- DECODE (1): alu_src_a=0, alu_src_b=11, ALUOp=110.
  - OP=0 goes to EXEC_R.
  - ADDI, ORI, ANDI and LUI go to EXEC_I.
  - LW and SW go to MEM_ADDR.
  - BEQ and BNE go to BRANCH.
  - Any other opcode goes to ERROR and sets illegal_op.
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, ALUOp=110. LW goes to MEM_READ; SW goes to MEM_WRITE.
- MEM_READ (3): i_or_d=1, mem_read=1. Go to MEM_WB on mem_ready.
- MEM_WB (4): reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEM_WRITE (5): i_or_d=1, mem_write=1. Go to FETCH on mem_ready.
- EXEC_R (6): alu_src_a=1, alu_src_b=00, ALUOp=111. Go to ALU_WB.
- EXEC_I (7): alu_src_a=1, alu_src_b=10, ALUOp=110/101/100/001 for ADDI/ORI/LUI/ANDI. Go to ALU_WB.
- ALU_WB (8): reg_write=1, mem_to_reg=0, reg_dst=(OP==0), ALUOp held as in the preceding EXEC state. Go to FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=00, ALUOp=000, pc_source=1, pc_write_cond_eq=(OP==BEQ), pc_write_cond_ne=(OP==BNE). Go to FETCH.
- ERROR (15): all control outputs 0. Held until reset.
- Codes 10-14 are unused; if reached, go to ERROR next cycle.

Wait counter (FETCH, MEM_READ, MEM_WRITE):
- Cleared on entering a wait state.
- Increments each cycle mem_ready is low.
- If the count equals WAIT_LIMIT-1 and mem_ready is low, the next state is ERROR and mem_timeout is set. Strobes are deasserted in ERROR.
- mem_ready high on the same cycle the limit is reached wins: normal transition, no timeout.

Retirement and cycle counts:
- instr_count increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH.
- instr_count wraps modulo 2^CNT_WIDTH.
- Latency with mem_ready always high: R/I = 4 cycles, LW = 5, SW = 4, BEQ/BNE = 3.

Test Plan:
- reset high 3 cycles, then OP=0x00, mem_ready=1 → state 0,1,6,8,0. reg_write=1 and reg_dst=1 in state 8. instr_count=1.
- LW (0x23), mem_ready low for 3 cycles in MEM_READ → states 0,1,2,3,3,3,3,4,0. mem_read=1 and i_or_d=1 throughout state 3. mem_to_reg=1 in state 4.
- BNE (0x05) → state 9 has pc_write_cond_ne=1, pc_write_cond_eq=0, ALUOp=000, pc_source=1. Back in FETCH on cycle 4.
- OP=0x3F → DECODE goes to ERROR. illegal_op=1; all strobes 0 for 20 cycles; instr_count unchanged. Reset recovers to FETCH.
- mem_ready held low in FETCH, WAIT_LIMIT=15 → ERROR after 15 cycles with mem_timeout=1. A repeat with mem_ready high on cycle 15 gives DECODE and no timeout.
- Assert reset during MEM_WRITE → outputs 0 immediately (asynchronous), state=0, instr_count=0. CNT_WIDTH=4 with 17 ADDIs → instr_count=1 (wrap).
